read_bpm_test_link: RTL and testbench

READ_BPM_TEST_LINK -- requirements
Module: read_bpm_test_link

---
 rtl/read_bpm_test_link_pkg.sv | 35 +++
 rtl/read_bpm_test_link_if.sv | 20 ++
 rtl/read_bpm_test_link.sv | 183 ++++++++++++++++++
 tb/tb_read_bpm_test_link.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_bpm_test_link_pkg.sv
// Shared BPM test link packet format: field layout, magic value and status codes.
// Used by both the receive side (readBPMTestLink) and the transmit side (writeBPMTestLink).
package read_bpm_test_link_pkg;

    localparam int                BPM_WORD_WIDTH      = 32;
    localparam int                BPM_MAGIC_WIDTH     = 16;
    localparam int                BPM_MAGIC_START_BIT = 16;
    localparam int                BPM_INDEX_WIDTH     = 5;
    localparam int                BPM_INDEX_START_BIT = 10;
    localparam int                BPM_NUM_DATA_WORDS  = 3;
    localparam logic [15:0]       BPM_HEADER_MAGIC    = 16'hA5BE;
    localparam int                BPM_COUNT_WIDTH     = 8;

    typedef enum logic [1:0] {
        STATUS_OK        = 2'd0,
        STATUS_BAD_MAGIC = 2'd1,
        STATUS_SHORT     = 2'd2,
        STATUS_LONG      = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_DATA    = 2'd1,
        ST_DISCARD = 2'd2
    } rx_state_t;

    // Per-FA-cycle counters stick at full scale rather than wrapping.
    function automatic logic [BPM_COUNT_WIDTH-1:0] sat_inc(input logic [BPM_COUNT_WIDTH-1:0] value);
        if (value == {BPM_COUNT_WIDTH{1'b1}}) begin
            return value;
        end
        return value + BPM_COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/read_bpm_test_link_if.sv
// AXI-Stream receive beat of the BPM test link (no back-pressure: every valid beat is taken).
interface read_bpm_test_link_if;

    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast
    );

    modport slave (
        input tdata,
        input tvalid,
        input tlast
    );

endinterface

// File: rtl/read_bpm_test_link.sv
// Decodes BPM test packets (header + NUM_DATA_WORDS words) from an Aurora AXIS stream,
// reports per-packet status and latches good/bad packet counts at every FA strobe.
module read_bpm_test_link
    import read_bpm_test_link_pkg::*;
#(
    parameter int                     MAGIC_WIDTH     = BPM_MAGIC_WIDTH,
    parameter int                     MAGIC_START_BIT = BPM_MAGIC_START_BIT,
    parameter int                     INDEX_WIDTH     = BPM_INDEX_WIDTH,
    parameter int                     INDEX_START_BIT = BPM_INDEX_START_BIT,
    parameter int                     NUM_DATA_WORDS  = BPM_NUM_DATA_WORDS,
    parameter logic [MAGIC_WIDTH-1:0] HEADER_MAGIC    = MAGIC_WIDTH'(BPM_HEADER_MAGIC)
) (
    input  logic                          auroraUserClk,
    input  logic                          auroraReset,
    input  logic                          auroraChannelUp,
    input  logic                          auroraFAstrobe,
    read_bpm_test_link_if.slave           BPM_TEST_AXI_STREAM_RX,
    output logic                          packetStrobe,
    output logic [INDEX_WIDTH-1:0]        packetIndex,
    output logic [32*NUM_DATA_WORDS-1:0]  packetData,
    output logic                          statusStrobe,
    output logic [1:0]                    statusCode,
    output logic [7:0]                    cycleGoodCount,
    output logic [7:0]                    cycleBadCount
);

    localparam int CNT_W    = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
    localparam int DATA_W   = 32 * NUM_DATA_WORDS;

    rx_state_t               state_q, state_d;
    logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
    logic [INDEX_WIDTH-1:0]  index_buf_q;
    logic [DATA_W-1:0]       data_buf_q, data_buf_d;
    status_t                 status_code_q, status_val;
    logic                    status_fire;
    logic                    packet_fire;
    logic                    capture_index;
    logic                    beat;
    logic                    magic_ok;
    logic                    last_word;
    logic [7:0]              good_cnt_q, bad_cnt_q;
    logic                    good_evt, bad_evt;

    assign beat      = auroraChannelUp && BPM_TEST_AXI_STREAM_RX.tvalid;
    assign magic_ok  = (BPM_TEST_AXI_STREAM_RX.tdata[MAGIC_START_BIT +: MAGIC_WIDTH] == HEADER_MAGIC);
    assign last_word = (word_cnt_q == CNT_W'(NUM_DATA_WORDS - 1));

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        data_buf_d    = data_buf_q;
        status_fire   = 1'b0;
        status_val    = STATUS_OK;
        packet_fire   = 1'b0;
        capture_index = 1'b0;

        if (beat) begin
            case (state_q)
                ST_HEADER: begin
                    if (magic_ok) begin
                        if (BPM_TEST_AXI_STREAM_RX.tlast) begin
                            status_fire = 1'b1;
                            status_val  = STATUS_SHORT;
                        end else begin
                            capture_index = 1'b1;
                            word_cnt_d    = '0;
                            state_d       = ST_DATA;
                        end
                    end else begin
                        status_fire = 1'b1;
                        status_val  = STATUS_BAD_MAGIC;
                        state_d     = BPM_TEST_AXI_STREAM_RX.tlast ? ST_HEADER : ST_DISCARD;
                    end
                end

                ST_DATA: begin
                    // First data word lands in the most significant slot.
                    for (int w = 0; w < NUM_DATA_WORDS; w++) begin
                        if (word_cnt_q == CNT_W'(w)) begin
                            data_buf_d[32*(NUM_DATA_WORDS-w)-1 -: 32] = BPM_TEST_AXI_STREAM_RX.tdata;
                        end
                    end
                    if (last_word) begin
                        status_fire = 1'b1;
                        if (BPM_TEST_AXI_STREAM_RX.tlast) begin
                            status_val  = STATUS_OK;
                            packet_fire = 1'b1;
                            state_d     = ST_HEADER;
                        end else begin
                            status_val  = STATUS_LONG;
                            state_d     = ST_DISCARD;
                        end
                    end else if (BPM_TEST_AXI_STREAM_RX.tlast) begin
                        status_fire = 1'b1;
                        status_val  = STATUS_SHORT;
                        state_d     = ST_HEADER;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end

                ST_DISCARD: begin
                    if (BPM_TEST_AXI_STREAM_RX.tlast) begin
                        state_d = ST_HEADER;
                    end
                end

                default: begin
                    state_d = ST_HEADER;
                end
            endcase
        end
    end

    // Losing the channel abandons any partial packet without reporting it.
    always_ff @(posedge auroraUserClk or posedge auroraReset) begin
        if (auroraReset) begin
            state_q    <= ST_HEADER;
            word_cnt_q <= '0;
        end else if (!auroraChannelUp) begin
            state_q    <= ST_HEADER;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_ff @(posedge auroraUserClk or posedge auroraReset) begin
        if (auroraReset) begin
            index_buf_q   <= '0;
            data_buf_q    <= '0;
            packetIndex   <= '0;
            packetData    <= '0;
            packetStrobe  <= 1'b0;
            statusStrobe  <= 1'b0;
            status_code_q <= STATUS_OK;
        end else begin
            data_buf_q   <= data_buf_d;
            packetStrobe <= packet_fire;
            statusStrobe <= status_fire;
            if (capture_index) begin
                index_buf_q <= BPM_TEST_AXI_STREAM_RX.tdata[INDEX_START_BIT +: INDEX_WIDTH];
            end
            if (status_fire) begin
                status_code_q <= status_val;
            end
            if (packet_fire) begin
                packetIndex <= index_buf_q;
                packetData  <= data_buf_d;
            end
        end
    end

    assign statusCode = status_code_q;

    // Counting is driven by the visible status strobe, so an FA strobe in the
    // same cycle as a status pulse pushes that event into the new FA cycle.
    assign good_evt = statusStrobe && (status_code_q == STATUS_OK);
    assign bad_evt  = statusStrobe && (status_code_q != STATUS_OK);

    always_ff @(posedge auroraUserClk or posedge auroraReset) begin
        if (auroraReset) begin
            good_cnt_q     <= '0;
            bad_cnt_q      <= '0;
            cycleGoodCount <= '0;
            cycleBadCount  <= '0;
        end else if (auroraFAstrobe) begin
            cycleGoodCount <= good_cnt_q;
            cycleBadCount  <= bad_cnt_q;
            good_cnt_q     <= {7'd0, good_evt};
            bad_cnt_q      <= {7'd0, bad_evt};
        end else begin
            if (good_evt) begin
                good_cnt_q <= sat_inc(good_cnt_q);
            end
            if (bad_evt) begin
                bad_cnt_q <= sat_inc(bad_cnt_q);
            end
        end
    end

endmodule

// File: tb/tb_read_bpm_test_link.sv
// Directed self-checking bench for read_bpm_test_link: packet decode, error statuses,
// FA-cycle counters, channel loss, gapped streams and mid-packet reset.
module tb_read_bpm_test_link;

    logic         clk = 1'b0;
    logic         rst;
    logic         channel_up;
    logic         fa_strobe;
    logic         packet_strobe;
    logic [4:0]   packet_index;
    logic [95:0]  packet_data;
    logic         status_strobe;
    logic [1:0]   status_code;
    logic [7:0]   cycle_good;
    logic [7:0]   cycle_bad;

    int           compared   = 0;
    int           mismatched = 0;
    int           pkt_seen   = 0;
    int           stat_seen  = 0;
    logic [1:0]   last_status = 2'd0;

    read_bpm_test_link_if rx_if ();

    read_bpm_test_link dut (
        .auroraUserClk          (clk),
        .auroraReset            (rst),
        .auroraChannelUp        (channel_up),
        .auroraFAstrobe         (fa_strobe),
        .BPM_TEST_AXI_STREAM_RX (rx_if),
        .packetStrobe           (packet_strobe),
        .packetIndex            (packet_index),
        .packetData             (packet_data),
        .statusStrobe           (status_strobe),
        .statusCode             (status_code),
        .cycleGoodCount         (cycle_good),
        .cycleBadCount          (cycle_bad)
    );

    always #5 clk = ~clk;

    // Strobes last one full clock, so each one is seen by exactly one falling edge.
    always @(negedge clk) begin
        if (packet_strobe === 1'b1) pkt_seen++;
        if (status_strobe === 1'b1) begin
            stat_seen++;
            last_status = status_code;
        end
    end

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic send_beat(input logic [31:0] data, input logic last, input bit gaps);
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            rx_if.tvalid = 1'b0;
            @(negedge clk);
        end
        rx_if.tdata  = data;
        rx_if.tlast  = last;
        rx_if.tvalid = 1'b1;
        @(negedge clk);
        rx_if.tvalid = 1'b0;
        rx_if.tlast  = 1'b0;
    endtask

    task automatic send_good(input logic [31:0] header, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input bit gaps);
        send_beat(header, 1'b0, gaps);
        send_beat(w0, 1'b0, gaps);
        send_beat(w1, 1'b0, gaps);
        send_beat(w2, 1'b1, gaps);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fa_pulse();
        fa_strobe = 1'b1;
        @(negedge clk);
        fa_strobe = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int p0, input int s0,
                                 input int exp_pkts, input int exp_stats, input logic [1:0] exp_code);
        check({tag, "_pkts"},  128'(pkt_seen - p0),  128'(exp_pkts));
        check({tag, "_stats"}, 128'(stat_seen - s0), 128'(exp_stats));
        if (exp_stats > 0) check({tag, "_code"}, 128'(last_status), 128'(exp_code));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pkt_strobe"},  128'(packet_strobe), 128'(0));
        check({tag, "_stat_strobe"}, 128'(status_strobe), 128'(0));
        check({tag, "_stat_code"},   128'(status_code),   128'(0));
        check({tag, "_index"},       128'(packet_index),  128'(0));
        check({tag, "_data"},        128'(packet_data),   128'(0));
        check({tag, "_cyc_good"},    128'(cycle_good),    128'(0));
        check({tag, "_cyc_bad"},     128'(cycle_bad),     128'(0));
    endtask

    initial begin
        int p0;
        int s0;
        logic [31:0] hdr;

        rst          = 1'b1;
        channel_up   = 1'b1;
        fa_strobe    = 1'b0;
        rx_if.tdata  = '0;
        rx_if.tvalid = 1'b0;
        rx_if.tlast  = 1'b0;

        idle(3);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Basic good packet, including one-cycle strobe timing.
        p0 = pkt_seen; s0 = stat_seen;
        send_good(32'hA5BE0400, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0);
        #1;
        check("good_pkt_strobe_high",  128'(packet_strobe), 128'(1));
        check("good_stat_strobe_high", 128'(status_strobe), 128'(1));
        check("good_stat_code",        128'(status_code),   128'(0));
        @(negedge clk);
        #1;
        check("good_pkt_strobe_low",   128'(packet_strobe), 128'(0));
        check("good_stat_strobe_low",  128'(status_strobe), 128'(0));
        idle(2);
        expect_result("good", p0, s0, 1, 1, 2'd0);
        check("good_index", 128'(packet_index), 128'(1));
        check("good_data",  128'(packet_data),  128'(96'h111111112222222233333333));

        // Bad magic, then recovery on the next good packet.
        p0 = pkt_seen; s0 = stat_seen;
        send_good(32'h12340400, 32'h44444444, 32'h55555555, 32'h66666666, 1'b0);
        idle(2);
        expect_result("badmagic", p0, s0, 0, 1, 2'd1);
        check("badmagic_index_hold", 128'(packet_index), 128'(1));
        check("badmagic_data_hold",  128'(packet_data),  128'(96'h111111112222222233333333));
        p0 = pkt_seen; s0 = stat_seen;
        send_good(32'hA5BE0800, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 1'b0);
        idle(2);
        expect_result("after_bad", p0, s0, 1, 1, 2'd0);
        check("after_bad_index", 128'(packet_index), 128'(2));
        check("after_bad_data",  128'(packet_data),  128'(96'hAAAAAAAABBBBBBBBCCCCCCCC));

        // Short packet: two data words.
        p0 = pkt_seen; s0 = stat_seen;
        send_beat(32'hA5BE0C00, 1'b0, 1'b0);
        send_beat(32'h01010101, 1'b0, 1'b0);
        send_beat(32'h02020202, 1'b1, 1'b0);
        idle(2);
        expect_result("short", p0, s0, 0, 1, 2'd2);
        check("short_index_hold", 128'(packet_index), 128'(2));

        // Long packet: four data words, the fourth discarded.
        p0 = pkt_seen; s0 = stat_seen;
        send_beat(32'hA5BE1000, 1'b0, 1'b0);
        send_beat(32'h0A0A0A0A, 1'b0, 1'b0);
        send_beat(32'h0B0B0B0B, 1'b0, 1'b0);
        send_beat(32'h0C0C0C0C, 1'b0, 1'b0);
        send_beat(32'h0D0D0D0D, 1'b1, 1'b0);
        idle(2);
        expect_result("long", p0, s0, 0, 1, 2'd3);
        p0 = pkt_seen; s0 = stat_seen;
        send_good(32'hA5BE1400, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 1'b0);
        idle(2);
        expect_result("after_long", p0, s0, 1, 1, 2'd0);
        check("after_long_index", 128'(packet_index), 128'(5));
        check("after_long_data",  128'(packet_data),  128'(96'h123456789ABCDEF00F0F0F0F));

        // Single-beat packets: good magic with tlast, then bad magic with tlast.
        p0 = pkt_seen; s0 = stat_seen;
        send_beat(32'hA5BE0400, 1'b1, 1'b0);
        idle(2);
        expect_result("hdr_last", p0, s0, 0, 1, 2'd2);
        p0 = pkt_seen; s0 = stat_seen;
        send_beat(32'hDEAD0000, 1'b1, 1'b0);
        idle(2);
        expect_result("bad_hdr_last", p0, s0, 0, 1, 2'd1);

        // FA counters: since reset 3 good, 5 bad.
        fa_pulse();
        check("fa1_good", 128'(cycle_good), 128'(3));
        check("fa1_bad",  128'(cycle_bad),  128'(5));
        send_good(32'hA5BE0400, 32'h1, 32'h2, 32'h3, 1'b0);
        send_good(32'hA5BE0400, 32'h4, 32'h5, 32'h6, 1'b0);
        send_good(32'hA5BE0400, 32'h7, 32'h8, 32'h9, 1'b0);
        send_good(32'h5A5A0400, 32'h7, 32'h8, 32'h9, 1'b0);
        idle(2);
        fa_pulse();
        check("fa2_good", 128'(cycle_good), 128'(3));
        check("fa2_bad",  128'(cycle_bad),  128'(1));
        send_good(32'hA5BE0400, 32'hA, 32'hB, 32'hC, 1'b0);
        fa_pulse();
        check("fa3_good", 128'(cycle_good), 128'(0));
        check("fa3_bad",  128'(cycle_bad),  128'(0));
        idle(2);
        fa_pulse();
        check("fa4_good", 128'(cycle_good), 128'(1));
        check("fa4_bad",  128'(cycle_bad),  128'(0));

        // Channel loss mid-packet drops it silently.
        p0 = pkt_seen; s0 = stat_seen;
        send_beat(32'hA5BE1800, 1'b0, 1'b0);
        send_beat(32'hEEEEEEEE, 1'b0, 1'b0);
        channel_up = 1'b0;
        send_beat(32'hEEEEEEEF, 1'b1, 1'b0);
        idle(2);
        channel_up = 1'b1;
        idle(1);
        send_good(32'hA5BE1C00, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0BADC0DE, 1'b0);
        idle(2);
        expect_result("chan_down", p0, s0, 1, 1, 2'd0);
        check("chan_down_index", 128'(packet_index), 128'(7));
        check("chan_down_data",  128'(packet_data),  128'(96'hCAFEF00DDEADBEEF0BADC0DE));

        // Twenty good packets with random valid gaps.
        p0 = pkt_seen; s0 = stat_seen;
        for (int i = 0; i < 20; i++) begin
            hdr = 32'hA5BE0000 | (32'(i) << 10);
            send_good(hdr, 32'hD0000000 + 32'(i), 32'hE0000000 + 32'(i), 32'hF0000000 + 32'(i), 1'b1);
            idle(2);
            check($sformatf("gap_index_%0d", i), 128'(packet_index), 128'(i));
            check($sformatf("gap_data_%0d", i), 128'(packet_data),
                  128'({32'hD0000000 + 32'(i), 32'hE0000000 + 32'(i), 32'hF0000000 + 32'(i)}));
        end
        expect_result("gaps", p0, s0, 20, 20, 2'd0);

        // Reset mid-packet, leftover words then decode as headers.
        send_beat(32'hA5BE0400, 1'b0, 1'b0);
        send_beat(32'h55555555, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1);
        #1;
        check_all_zero("mid_reset");
        rst = 1'b0;
        @(negedge clk);
        p0 = pkt_seen; s0 = stat_seen;
        send_beat(32'h66666666, 1'b0, 1'b0);
        send_beat(32'h77777777, 1'b1, 1'b0);
        idle(2);
        expect_result("post_reset", p0, s0, 0, 1, 2'd1);
        p0 = pkt_seen; s0 = stat_seen;
        send_good(32'hA5BE2000, 32'h13579BDF, 32'h2468ACE0, 32'hFEDCBA98, 1'b0);
        idle(2);
        expect_result("post_reset_good", p0, s0, 1, 1, 2'd0);
        check("post_reset_index", 128'(packet_index), 128'(8));
        check("post_reset_data",  128'(packet_data),  128'(96'h13579BDF2468ACE0FEDCBA98));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
